// File: rtl/context_forward_unit.sv
// Context forwarding unit for a context-memory read/modify/write pipeline.
// Detects lookups that target a context whose update has not yet landed in
// memory: the live writeback or one of HIST_DEPTH registered writebacks.
// The youngest matching record is forwarded and the memory read is suppressed.
module context_forward_unit #(
  parameter int unsigned Q_length   = 9,
  parameter int unsigned A_length   = 13,
  parameter int unsigned B_length   = 7,
  parameter int unsigned C_length   = 8,
  parameter int unsigned N_length   = 7,
  parameter int unsigned Nn_length  = 7,
  parameter int unsigned Context_rw = 2,
  parameter int unsigned HIST_DEPTH = 2,
  localparam int unsigned HitW      = $clog2(HIST_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_enc,
  input  logic [Q_length-1:0]   Q,
  input  logic                  flush,
  input  logic                  start_enc_feedback,
  input  logic [Context_rw-1:0] determineWrite,
  input  logic [Q_length-1:0]   Q_Feedback,
  input  logic [A_length-1:0]   A_Feedback,
  input  logic [B_length-1:0]   B_Feedback,
  input  logic [C_length-1:0]   C_Feedback,
  input  logic [N_length-1:0]   N_Feedback,
  input  logic [Nn_length-1:0]  Nn_Feedback,
  output logic                  read_Context_Memory,
  output logic [Q_length-1:0]   Q_Read,
  output logic [Context_rw-1:0] write_Context_Memory,
  output logic [Q_length-1:0]   Q_Write,
  output logic [A_length-1:0]   A_Write,
  output logic [B_length-1:0]   B_Write,
  output logic [C_length-1:0]   C_Write,
  output logic [N_length-1:0]   N_Write,
  output logic [Nn_length-1:0]  Nn_Write,
  output logic                  useFeedbackValues,
  output logic [Q_length-1:0]   Q_Updated,
  output logic [A_length-1:0]   A_Updated,
  output logic [B_length-1:0]   B_Updated,
  output logic [C_length-1:0]   C_Updated,
  output logic [N_length-1:0]   N_Updated,
  output logic [Nn_length-1:0]  Nn_Updated,
  output logic [HitW-1:0]       hit_index
);

  // Writeback history: entry 0 is the youngest.
  logic [HIST_DEPTH-1:0] r_hist_valid;
  logic [Q_length-1:0]   r_hist_q  [HIST_DEPTH];
  logic [A_length-1:0]   r_hist_a  [HIST_DEPTH];
  logic [B_length-1:0]   r_hist_b  [HIST_DEPTH];
  logic [C_length-1:0]   r_hist_c  [HIST_DEPTH];
  logic [N_length-1:0]   r_hist_n  [HIST_DEPTH];
  logic [Nn_length-1:0]  r_hist_nn [HIST_DEPTH];

  // Registered forwarding result.
  logic                  r_use;
  logic [Q_length-1:0]   r_upd_q;
  logic [A_length-1:0]   r_upd_a;
  logic [B_length-1:0]   r_upd_b;
  logic [C_length-1:0]   r_upd_c;
  logic [N_length-1:0]   r_upd_n;
  logic [Nn_length-1:0]  r_upd_nn;
  logic [HitW-1:0]       r_hit_index;

  // Combinational match results.
  logic                  w_live;
  logic                  w_match;
  logic                  w_hit;
  logic [HitW-1:0]       w_sel_idx;
  logic [Q_length-1:0]   w_sel_q;
  logic [A_length-1:0]   w_sel_a;
  logic [B_length-1:0]   w_sel_b;
  logic [C_length-1:0]   w_sel_c;
  logic [N_length-1:0]   w_sel_n;
  logic [Nn_length-1:0]  w_sel_nn;

  // A writeback with an all-zero mask changes nothing in memory, so it is
  // not a forwarding source and does not enter the history.
  assign w_live = start_enc_feedback && (determineWrite != '0);

  // Memory-side pass-through.
  assign Q_Read               = Q;
  assign Q_Write              = Q_Feedback;
  assign A_Write              = A_Feedback;
  assign B_Write              = B_Feedback;
  assign C_Write              = C_Feedback;
  assign N_Write              = N_Feedback;
  assign Nn_Write             = Nn_Feedback;
  assign write_Context_Memory = start_enc_feedback ? determineWrite : '0;

  // Priority match: scan oldest to youngest so later (younger) hits
  // overwrite earlier ones; the live feedback is checked last and wins.
  // History is masked during a flush cycle, the live feedback is not.
  always_comb begin
    w_match   = 1'b0;
    w_sel_idx = '0;
    w_sel_q   = '0;
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_c   = '0;
    w_sel_n   = '0;
    w_sel_nn  = '0;
    for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
      if (r_hist_valid[i] && !flush && (r_hist_q[i] == Q)) begin
        w_match   = 1'b1;
        w_sel_idx = HitW'(i + 1);
        w_sel_q   = r_hist_q[i];
        w_sel_a   = r_hist_a[i];
        w_sel_b   = r_hist_b[i];
        w_sel_c   = r_hist_c[i];
        w_sel_n   = r_hist_n[i];
        w_sel_nn  = r_hist_nn[i];
      end
    end
    if (w_live && (Q_Feedback == Q)) begin
      w_match   = 1'b1;
      w_sel_idx = '0;
      w_sel_q   = Q_Feedback;
      w_sel_a   = A_Feedback;
      w_sel_b   = B_Feedback;
      w_sel_c   = C_Feedback;
      w_sel_n   = N_Feedback;
      w_sel_nn  = Nn_Feedback;
    end
  end

  assign w_hit               = start_enc && w_match;
  assign read_Context_Memory = start_enc && !w_hit;

  // History valid bits: reset, then flush, then shift-in on a live writeback.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hist_valid <= '0;
    end else if (flush) begin
      r_hist_valid <= '0;
    end else if (w_live) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        r_hist_valid[i] <= r_hist_valid[i-1];
      end
      r_hist_valid[0] <= 1'b1;
    end
  end

  // History payload shifts on every live writeback; contents behind a cleared
  // valid bit are never observed, so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (w_live) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        r_hist_q[i]  <= r_hist_q[i-1];
        r_hist_a[i]  <= r_hist_a[i-1];
        r_hist_b[i]  <= r_hist_b[i-1];
        r_hist_c[i]  <= r_hist_c[i-1];
        r_hist_n[i]  <= r_hist_n[i-1];
        r_hist_nn[i] <= r_hist_nn[i-1];
      end
      r_hist_q[0]  <= Q_Feedback;
      r_hist_a[0]  <= A_Feedback;
      r_hist_b[0]  <= B_Feedback;
      r_hist_c[0]  <= C_Feedback;
      r_hist_n[0]  <= N_Feedback;
      r_hist_nn[0] <= Nn_Feedback;
    end
  end

  // Forwarding flag follows every lookup; it holds between lookups.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_use <= 1'b0;
    end else if (start_enc) begin
      r_use <= w_hit;
    end
  end

  // Forwarded record and its source position update only on a hit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_upd_q     <= '0;
      r_upd_a     <= '0;
      r_upd_b     <= '0;
      r_upd_c     <= '0;
      r_upd_n     <= '0;
      r_upd_nn    <= '0;
      r_hit_index <= '0;
    end else if (w_hit) begin
      r_upd_q     <= w_sel_q;
      r_upd_a     <= w_sel_a;
      r_upd_b     <= w_sel_b;
      r_upd_c     <= w_sel_c;
      r_upd_n     <= w_sel_n;
      r_upd_nn    <= w_sel_nn;
      r_hit_index <= w_sel_idx;
    end
  end

  assign useFeedbackValues = r_use;
  assign Q_Updated         = r_upd_q;
  assign A_Updated         = r_upd_a;
  assign B_Updated         = r_upd_b;
  assign C_Updated         = r_upd_c;
  assign N_Updated         = r_upd_n;
  assign Nn_Updated        = r_upd_nn;
  assign hit_index         = r_hit_index;

endmodule

// File: doc/context_forward_unit.md
CONTEXT_FORWARD_UNIT -- requirements
Module: context_forward_unit

Interface
REQ-001 The block SHALL have a parameter Q_length, default 9, giving the context index width.
REQ-002 The block SHALL have parameters A_length, B_length, C_length, N_length and Nn_length, defaulting to the codebase-wide values, giving the context field widths.
REQ-003 The block SHALL have a parameter Context_rw, default 2, giving the write-mask width: bit 0 = regular-mode update, bit 1 = run-interruption update.
REQ-004 The block SHALL have a parameter HIST_DEPTH, default 2, legal range 1..8, giving the number of registered writeback history entries.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 start_enc  input  1  context lookup request this cycle.
REQ-008 Q  input  Q_length  context index being looked up.
REQ-009 flush  input  1  invalidates all history entries (image/scan boundary).
REQ-010 start_enc_feedback  input  1  writeback valid this cycle.
REQ-011 determineWrite  input  Context_rw  write mask for the writeback.
REQ-012 Q_Feedback, A_Feedback, B_Feedback, C_Feedback, N_Feedback, Nn_Feedback  input  respective widths  full updated context record; all fields are always carried, whatever the mask.
REQ-013 read_Context_Memory  output  1  memory read enable.
REQ-014 Q_Read  output  Q_length  memory read address.
REQ-015 write_Context_Memory  output  Context_rw  memory write mask.
REQ-016 Q_Write, A_Write, B_Write, C_Write, N_Write, Nn_Write  output  respective widths  memory write address and data.
REQ-017 useFeedbackValues  output  1  registered: *_Updated replaces the memory read data.
REQ-018 Q_Updated, A_Updated, B_Updated, C_Updated, N_Updated, Nn_Updated  output  respective widths  registered forwarded record.
REQ-019 hit_index  output  clog2(HIST_DEPTH+1)  registered: 0 = live feedback, k = history entry k-1.

Function
REQ-020 Q_Read SHALL equal Q combinationally.
REQ-021 Each *_Write output SHALL equal its *_Feedback input combinationally.
REQ-022 write_Context_Memory SHALL equal determineWrite when start_enc_feedback=1, and 0 otherwise.
REQ-023 A writeback SHALL be "live" when start_enc_feedback=1 and determineWrite!=0.
REQ-024 Each history entry SHALL hold: valid, Q, A, B, C, N, Nn.
REQ-025 History SHALL shift on every live writeback: the feedback record enters entry 0 with valid=1, entry k moves to k+1, and the oldest entry is discarded.
REQ-026 History SHALL hold its contents in any cycle without a live writeback.
REQ-027 Candidates, in priority order (youngest first), SHALL be: the live feedback, then entry 0 .. entry HIST_DEPTH-1; only valid entries participate.
REQ-028 hit SHALL be 1 when start_enc=1 and any candidate's Q equals Q; the youngest match is selected.
REQ-029 Q=0 SHALL be a legal context; no special-casing by value and no warm-up counter; valid bits alone gate matching.
REQ-030 read_Context_Memory SHALL equal start_enc AND NOT hit, combinationally.
REQ-031 On a clock edge with start_enc=1: useFeedbackValues <= hit; if hit, *_Updated <= the selected record and hit_index <= its position; if no hit, *_Updated and hit_index hold.
REQ-032 On a clock edge with start_enc=0: useFeedbackValues, *_Updated and hit_index SHALL hold.
REQ-033 A live writeback and a lookup of the same Q in the same cycle SHALL forward the live feedback (hit_index=0); the memory write still occurs.
REQ-034 When flush=1, all valid bits SHALL clear at the edge, overriding a same-cycle shift.
REQ-035 During a flush cycle, lookup SHALL still see the live feedback but not the history.
REQ-036 The block SHALL be stall-safe: arbitrary start_enc or start_enc_feedback gaps SHALL not corrupt history order.

Reset
REQ-037 When reset=0 at a clock edge, all history valid bits, useFeedbackValues, hit_index and all *_Updated outputs SHALL be 0.
REQ-038 reset SHALL take priority over flush, writebacks and lookups.
REQ-039 Combinational outputs SHALL continue to follow their inputs while reset is asserted.
REQ-040 After reset, no forwarding hit SHALL be possible until a live writeback occurs.

Verification
REQ-041 Reset, then lookup Q=0 with no writebacks -> read_Context_Memory=1, useFeedbackValues=0 next cycle (no false hit on Q=0).
REQ-042 Live writeback Q=5, A=100, mask=01, with same-cycle lookup Q=5 -> read=0, write_Context_Memory=01; next cycle useFeedbackValues=1, A_Updated=100, hit_index=0.
REQ-043 HIST_DEPTH=2: writebacks Q=7 (A=10) then Q=7 (A=20), then lookup Q=7 -> A_Updated=20, hit_index=1.
REQ-044 HIST_DEPTH=2: writebacks Q=3, 4, 6, then lookup Q=3 -> read=1, useFeedbackValues=0 (oldest entry evicted).
REQ-045 Writeback Q=9, then flush, then lookup Q=9 -> read=1, no hit.
REQ-046 Writeback with mask=00 for Q=2, then lookup Q=2 -> no hit, history unchanged, write_Context_Memory=00.
